fetch_unit: RTL and testbench

- Instruction fetch stage. Produces the instruction word whose op/funct3/funct7 fields feed the control decoder.
- Owns the PC register and issues word-aligned requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words with their PCs and presents them to decode over a valid/ready handshake.
- Supports a redirect (taken branch/jump) that flushes all wrong-path state.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions.
//   XLEN             : datapath and address width
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
//   INSTR_NOP        : canonical no-op (addi x0, x0, 0)
//   fetch_entry_t    : {pc, instr} pair handed from fetch to decode
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, the branch unit
// (redirect) and decode.
//   master : fetch unit side (drives requests and decode-facing outputs)
//   slave  : environment side (memory, redirect source, decode)
interface fetch_unit_if #(
  parameter int XLEN = fetch_unit_pkg::XLEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small first-word fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (storage is cleared too so the
//                head reads as zero out of reset)
//   flush_i    : empties the FIFO; wins over push/pop
//   push_i     : write data_i (ignored when full unless popping the same cycle)
//   pop_i      : drop the head entry (ignored when empty)
//   data_o     : current head entry
//   count_o    : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  T                             data_i,
  output T                             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                mem_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  // Full + pop + push in one cycle is legal: the freed slot is reused.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_unit_if.master
//     imem_req_*  word-aligned fetch requests (valid/ready)
//     imem_rsp_*  in-order responses, always accepted
//     redirect*   one-cycle restart pulse with target PC
//     if_*        buffered {pc, instr} towards decode (valid/ready, FWFT)
// Credit rule: in-flight requests + buffered words never exceed DEPTH, so the
// buffer cannot overflow and responses need no backpressure.
module fetch_unit #(
  parameter int              XLEN     = fetch_unit_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_unit_pkg::RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    bus
);

  import fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   outstanding, count;
  logic            req_fire, rsp_discard, buf_push, buf_pop;
  logic [XLEN-1:0] rsp_pc;
  entry_t          rsp_entry, head;

  // rst_n gating keeps the request quiet while reset is held.
  assign bus.imem_req_valid = rst_n && !bus.redirect &&
                              (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_discard = bus.redirect || (drop_q != '0);
  assign buf_push    = bus.imem_rsp_valid && !rsp_discard;
  assign buf_pop     = bus.if_valid && bus.if_ready;
  assign rsp_entry   = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  // PC of every in-flight request; its occupancy is the outstanding count.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pc_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .pop_i   (bus.imem_rsp_valid),
    .data_i  (pc_q),
    .data_o  (rsp_pc),
    .count_o (outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.redirect),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .data_i  (rsp_entry),
    .data_o  (head),
    .count_o (count)
  );

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (bus.redirect) begin
      pc_d   = bus.redirect_pc & ~XLEN'(3);
      // Every request still in flight after this edge belongs to the old path.
      drop_d = outstanding - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  assign bus.if_valid    = (count != '0);
  assign bus.if_instr    = head.instr;
  assign bus.if_pc       = head.pc;
  assign bus.if_pc_plus4 = head.pc + XLEN'(4);

  a_drop_le_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) drop_q <= outstanding);

  a_rsp_has_request: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(32)) busw ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busw.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural fetch stream as queues.
  logic [31:0] m_pc;
  logic [31:0] fl_pc[$];
  bit          fl_bad[$];
  logic [31:0] bq_pc[$];
  logic [31:0] bq_ins[$];

  // Memory environment.
  int mq_due[$];
  int cyc = 0;
  int lat = 1;

  // Observations.
  logic [31:0] fired[$];
  logic [31:0] popped[$];
  bit          obs_rv, obs_ifv;
  logic [31:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    fl_pc.delete(); fl_bad.delete();
    bq_pc.delete(); bq_ins.delete();
    mq_due.delete();
    fired.delete(); popped.delete();
  endtask

  // One clock: sample/check at negedge, update model, then drive memory
  // outputs for the next window at posedge+1.
  task automatic tick();
    bit exp_rv, exp_ifv, fire_env, b;
    logic [31:0] p;
    @(negedge clk);
    exp_rv  = ((fl_pc.size() + bq_pc.size()) < DEPTH) && !bus.redirect;
    exp_ifv = (bq_pc.size() != 0);
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", bus.imem_req_addr, m_pc);
    check("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
    if (exp_ifv) begin
      check("if_pc", bus.if_pc, bq_pc[0]);
      check("if_instr", bus.if_instr, bq_ins[0]);
      check("if_pc_plus4", bus.if_pc_plus4, bq_pc[0] + 32'd4);
    end
    obs_rv   = bus.imem_req_valid;
    obs_ifv  = bus.if_valid;
    obs_addr = bus.imem_req_addr;
    fire_env = bus.imem_req_valid && bus.imem_req_ready;
    if (fire_env) fired.push_back(bus.imem_req_addr);
    if (bus.if_valid && bus.if_ready && !bus.redirect) popped.push_back(bus.if_pc);

    if (bus.redirect) begin
      if (bus.imem_rsp_valid && fl_pc.size() > 0) begin
        void'(fl_pc.pop_front());
        void'(fl_bad.pop_front());
      end
      foreach (fl_bad[i]) fl_bad[i] = 1'b1;
      bq_pc.delete(); bq_ins.delete();
      m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (exp_ifv && bus.if_ready) begin
        void'(bq_pc.pop_front());
        void'(bq_ins.pop_front());
      end
      if (bus.imem_rsp_valid && fl_pc.size() > 0) begin
        p = fl_pc.pop_front();
        b = fl_bad.pop_front();
        if (!b) begin
          bq_pc.push_back(p);
          bq_ins.push_back(bus.imem_rsp_data);
        end
      end
      if (exp_rv && bus.imem_req_ready) begin
        fl_pc.push_back(m_pc);
        fl_bad.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    bus.redirect = 1'b0;
    if (fire_env) mq_due.push_back(cyc + lat - 1);
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      void'(mq_due.pop_front());
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
    end else begin
      bus.imem_rsp_valid = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    bus.imem_rsp_valid = 1'b0;
    bus.redirect       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_if;
    bit found;
    int old_cnt;

    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b0;
    busw.imem_req_ready = 1'b0; busw.imem_rsp_valid = 1'b0; busw.imem_rsp_data = '0;
    busw.redirect = 1'b0; busw.redirect_pc = '0; busw.if_ready = 1'b0;
    model_reset();

    // Reset values.
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_instr", bus.if_instr, 32'd0);
    check("rst_if_pc", bus.if_pc, 32'd0);
    check("rst_w_req_valid", 32'(busw.imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A: streaming, latency 1, decode always ready.
    do_reset();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    first_if = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (obs_ifv && first_if < 0) first_if = k;
    end
    check("A_first_if_cycle", 32'(first_if), 32'd2);
    for (int i = 0; i < 4; i++)
      check("A_req_seq", (fired.size() > i) ? fired[i] : 32'hDEAD_BEEF, 32'(4 * i));
    for (int i = 0; i < 3; i++)
      check("A_if_seq", (popped.size() > i) ? popped[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // B: decode stalled, credits exhaust after DEPTH requests.
    do_reset();
    bus.if_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("B_fire_cnt", 32'(fired.size()), 32'd2);
    check("B_req_idle", 32'(obs_rv), 32'd0);
    fired.delete(); popped.delete();
    bus.if_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("B_pop0", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h0);
    check("B_pop1", (popped.size() > 1) ? popped[1] : 32'hDEAD_BEEF, 32'h4);
    check("B_resume", (fired.size() > 0) ? fired[0] : 32'hDEAD_BEEF, 32'h8);

    // C: latency 3, two in flight, redirect to 0x100.
    do_reset();
    lat = 3;
    tick();
    tick();
    check("C_inflight", 32'(fired.size()), 32'd2);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    tick();
    fired.delete(); popped.delete();
    for (int k = 0; k < 14; k++) tick();
    check("C_first_req", (fired.size() > 0) ? fired[0] : 32'hDEAD_BEEF, 32'h100);
    check("C_first_if", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h100);
    old_cnt = 0;
    foreach (popped[i]) if (popped[i] < 32'h100) old_cnt++;
    check("C_old_words", 32'(old_cnt), 32'd0);

    // D: redirect together with a response and an if handshake.
    do_reset();
    lat = 1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (bus.imem_rsp_valid && bq_pc.size() > 0) found = 1'b1;
    end
    check("D_setup_found", 32'(found), 32'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    tick();
    popped.delete();
    tick();
    check("D_next_req_valid", 32'(obs_rv), 32'd1);
    check("D_next_req_addr", obs_addr, 32'h200);
    for (int k = 0; k < 8; k++) tick();
    check("D_first_if", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h200);

    // E: PC wrap on the second instance.
    do_reset();
    busw.imem_req_ready = 1'b1;
    #1;
    check("E_req_valid0", 32'(busw.imem_req_valid), 32'd1);
    check("E_req_addr0", busw.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    busw.imem_rsp_valid = 1'b1;
    busw.imem_rsp_data  = 32'h1234_5678;
    #1;
    check("E_req_addr1", busw.imem_req_addr, 32'h0000_0000);
    check("E_req_valid1", 32'(busw.imem_req_valid), 32'd1);
    tick();
    busw.imem_rsp_valid = 1'b0;
    busw.imem_req_ready = 1'b0;
    #1;
    check("E_if_valid", 32'(busw.if_valid), 32'd1);
    check("E_if_pc", busw.if_pc, 32'hFFFF_FFFC);
    check("E_if_pc_plus4", busw.if_pc_plus4, 32'h0000_0000);
    check("E_if_instr", busw.if_instr, 32'h1234_5678);
    check("E_credit_stop", 32'(busw.imem_req_valid), 32'd0);

    // F: asynchronous reset with a full buffer.
    do_reset();
    bus.if_ready = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("F_pre_if_valid", 32'(obs_ifv), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("F_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("F_rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("F_rst_if_instr", bus.if_instr, 32'd0);
    check("F_rst_if_pc", bus.if_pc, 32'd0);
    model_reset();
    bus.imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    tick();
    check("F_restart_addr", (fired.size() > 0) ? fired[0] : 32'hDEAD_BEEF, 32'h0);

    // G: randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ((k % 64) == 0 && mq_due.size() == 0) lat = $urandom_range(1, 3);
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = $urandom;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
